// File: rtl/mux_nx1_stream_scan_if.sv
// ---------------------------------------------------------------------------
// mux_nx1_stream_scan_if
// Bus bundle for the N:1 streaming selector: the wide parallel input word
// with its valid/ready pair, and the registered single-channel output with
// its valid/ready pair plus channel tag and error flag.
//
//   in_data   [NCH*WIDTH]  channel k at bits [k*WIDTH +: WIDTH]
//   in_valid               producer has a word on in_data
//   in_ready               selector takes in_data this cycle
//   out_data  [WIDTH]      selected channel word
//   out_sel   [SELW]       channel index that produced out_data
//   out_err                out_data came from an out-of-range manual sel
//   out_valid              output register holds an untaken word
//   out_ready              consumer takes the output word
//
// master : the side that drives in_data/in_valid and out_ready
// slave  : the selector itself
// ---------------------------------------------------------------------------
interface mux_nx1_stream_scan_if #(
   parameter int WIDTH = 8,
   parameter int NCH   = 8,
   parameter int SELW  = $clog2(NCH)
);
   logic [NCH*WIDTH-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_sel;
   logic                 out_err;
   logic                 out_valid;
   logic                 out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_sel, out_err, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_sel, out_err, out_valid
   );
endinterface

// File: rtl/mux_nx1_stream_scan.sv
// ---------------------------------------------------------------------------
// mux_nx1_stream_scan
// NCH-channel, WIDTH-bit selector with a single registered output stage and
// valid/ready flow control. In manual mode the channel comes from sel; in
// scan mode an internal round-robin scanner walks the channels enabled in
// ch_mask, taking DWELL accepted words from each before moving on.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   bus      slave side of mux_nx1_stream_scan_if (in/out streams)
//   sel      manual channel index (may exceed NCH-1; flagged as error)
//   mode     0 = manual, 1 = scan
//   ch_mask  channel enables for scan mode
// ---------------------------------------------------------------------------
module mux_nx1_stream_scan #(
   parameter int WIDTH = 8,
   parameter int NCH   = 8,
   parameter int DWELL = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   mux_nx1_stream_scan_if.slave    bus,
   input  logic [$clog2(NCH)-1:0]  sel,
   input  logic                    mode,
   input  logic [NCH-1:0]          ch_mask
);

   localparam int SELW = $clog2(NCH);
   localparam int NPAD = 1 << SELW;   // channel count padded to a power of two
   localparam int NQ   = SELW / 2;    // number of 4:1 tree levels
   localparam int DCW  = 8;           // dwell counter width (DWELL <= 255)

   // -------------------------------------------------------------------------
   // Helper functions
   // -------------------------------------------------------------------------

   // Enable bit of channel ch, written as a mask test so that index values
   // beyond NCH-1 simply read as disabled.
   function automatic logic mask_bit(input logic [NCH-1:0]  mask,
                                     input logic [SELW-1:0] ch);
      return |(mask & (NCH'(1) << ch));
   endfunction

   // Next enabled channel strictly after cur, wrapping NCH-1 -> 0. When cur
   // is the only enabled channel the search comes back around to cur.
   function automatic logic [SELW-1:0] next_ch(input logic [NCH-1:0]  mask,
                                               input logic [SELW-1:0] cur);
      logic [SELW-1:0] res;
      logic            found;
      int              idx;
      res   = cur;
      found = 1'b0;
      for (int i = 1; i <= NCH; i++) begin
         idx = (int'(cur) + i) % NCH;
         if (!found && ((mask & (NCH'(1) << idx)) != '0)) begin
            res   = SELW'(idx);
            found = 1'b1;
         end
      end
      return res;
   endfunction

   // Lowest enabled channel, 0 when nothing is enabled.
   function automatic logic [SELW-1:0] first_ch(input logic [NCH-1:0] mask);
      logic [SELW-1:0] res;
      res = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if ((mask & (NCH'(1) << i)) != '0) res = SELW'(i);
      end
      return res;
   endfunction

   function automatic logic [WIDTH-1:0] mux4(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] c,
                                             input logic [WIDTH-1:0] d,
                                             input logic [1:0]       s);
      logic [WIDTH-1:0] r;
      unique case (s)
         2'd0:    r = a;
         2'd1:    r = b;
         2'd2:    r = c;
         default: r = d;
      endcase
      return r;
   endfunction

   // -------------------------------------------------------------------------
   // Declarations
   // -------------------------------------------------------------------------
   logic [SELW-1:0]  scan_ch;
   logic [DCW-1:0]   dwell_cnt;
   logic             mode_q;

   logic [WIDTH-1:0] data_p1;
   logic [SELW-1:0]  sel_p1;
   logic             err_p1;
   logic             vld_p1;

   logic             mode_switch;
   logic             mask_empty;
   logic             cur_off;
   logic             scan_block;
   logic             accept;
   logic             xfer;
   logic             sel_oob;
   logic             err_p0;
   logic [SELW-1:0]  eff_ch;
   logic [WIDTH-1:0] tree_out;
   logic [WIDTH-1:0] data_p0;

   // -------------------------------------------------------------------------
   // Stage p0: handshake, channel choice and selection tree (combinational)
   // -------------------------------------------------------------------------
   assign mode_switch = mode & ~mode_q;
   assign mask_empty  = (ch_mask == '0);
   assign cur_off     = ~mask_bit(ch_mask, scan_ch);

   // In scan mode nothing is taken while the scanner is not parked on an
   // enabled channel: first cycle after entering scan, a mask that just
   // dropped the current channel, or an empty mask.
   assign scan_block  = mode & (mask_empty | cur_off | mode_switch);
   assign bus.in_ready = (~vld_p1 | bus.out_ready) & ~scan_block;

   assign accept = bus.in_valid & bus.in_ready;
   assign xfer   = vld_p1 & bus.out_ready;

   // Widened by one bit so the comparison is meaningful even when NCH is a
   // power of two.
   assign sel_oob = ({1'b0, sel} >= (SELW + 1)'(NCH));
   assign eff_ch  = mode ? scan_ch : sel;
   assign err_p0  = ~mode & sel_oob;

   // Radix-4 tree: level g consumes eff_ch bits [2g-1:2g-2]; an odd SELW
   // leaves one 2:1 level at the top driven by the MSB. Padded leaves are 0.
   for (genvar g = 0; g <= NQ; g++) begin : st
      localparam int CNT = NPAD >> (2 * g);
      logic [WIDTH-1:0] node [CNT];
      if (g == 0) begin : lf
         for (genvar j = 0; j < NPAD; j++) begin : l
            if (j < NCH) begin : used
               assign node[j] = bus.in_data[j*WIDTH +: WIDTH];
            end else begin : pad
               assign node[j] = '0;
            end
         end
      end else begin : q
         for (genvar j = 0; j < CNT; j++) begin : m
            assign node[j] = mux4(st[g-1].node[4*j],   st[g-1].node[4*j+1],
                                  st[g-1].node[4*j+2], st[g-1].node[4*j+3],
                                  eff_ch[2*g-1 -: 2]);
         end
      end
   end

   if (SELW % 2 == 1) begin : fin2
      assign tree_out = eff_ch[SELW-1] ? st[NQ].node[1] : st[NQ].node[0];
   end else begin : fin1
      assign tree_out = st[NQ].node[0];
   end

   assign data_p0 = err_p0 ? '0 : tree_out;

   // -------------------------------------------------------------------------
   // Stage p1: output register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         sel_p1  <= '0;
         err_p1  <= 1'b0;
      end else if (accept) begin
         vld_p1  <= 1'b1;
         data_p1 <= data_p0;
         sel_p1  <= eff_ch;
         err_p1  <= err_p0;
      end else if (xfer) begin
         vld_p1  <= 1'b0;
      end
   end

   assign bus.out_valid = vld_p1;
   assign bus.out_data  = data_p1;
   assign bus.out_sel   = sel_p1;
   assign bus.out_err   = err_p1;

   // -------------------------------------------------------------------------
   // Scanner state: frozen in manual mode, mode_q always tracks mode
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_ch   <= '0;
         dwell_cnt <= '0;
         mode_q    <= 1'b0;
      end else begin
         mode_q <= mode;
         if (mode) begin
            if (mode_switch) begin
               scan_ch   <= first_ch(ch_mask);
               dwell_cnt <= '0;
            end else if (!mask_empty && cur_off) begin
               // Current channel was disabled mid-dwell: hop without accepting.
               scan_ch   <= next_ch(ch_mask, scan_ch);
               dwell_cnt <= '0;
            end else if (accept) begin
               if (dwell_cnt == DCW'(DWELL - 1)) begin
                  scan_ch   <= next_ch(ch_mask, scan_ch);
                  dwell_cnt <= '0;
               end else begin
                  dwell_cnt <= dwell_cnt + DCW'(1);
               end
            end
         end
      end
   end

endmodule
